// File: rtl/nes_cpu_pkg.sv
// Shared NES CPU-side definitions: sprite DMA state encoding and fixed addresses.
package nes_cpu_pkg;

  // DMA sequencer states. ALIGN is only reachable when the odd-cycle
  // alignment feature is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] OAM_DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR     = 16'h2004;
  localparam int          OAM_DMA_LEN       = 256;

endpackage

// File: rtl/oam_dma_arb.sv
// Bus arbiter between the CPU core and the CPU memory controller.
// Passes CPU cycles through; a write to TRIG_ADDR stalls the CPU and copies
// XFER_LEN bytes from page {page, 8'h00} to DST_ADDR, one read/write pair per byte.
// Optional: define OAM_DMA_ODD_ALIGN_EN to insert one ALIGN stall cycle when
// START falls on an odd cycle (513 or 514 stall cycles, as on the NES).
//
// state | meaning
// IDLE  | CPU owns the bus, combinational pass-through
// START | trigger write retires, CPU stalled, bus idle
// ALIGN | extra idle stall cycle for odd-cycle alignment (feature only)
// READ  | present source address {page, cnt}
// WRITE | write previous read data to DST_ADDR, advance or finish
module oam_dma_arb
  import nes_cpu_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = OAM_DMA_TRIG_ADDR,
  parameter logic [15:0] DST_ADDR  = OAM_DATA_ADDR,
  // Power of two, at most 256, so the byte counter never leaves the page.
  parameter int          XFER_LEN  = OAM_DMA_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [15:0] mc_addr,
  output logic        mc_wr,
  output logic [7:0]  mc_din,
  input  logic [7:0]  mc_dout,
  output logic        dma_active
);

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  dma_state_e  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_cnt;
  logic        w_trig;

  assign w_trig  = cpu_wr && (cpu_addr == TRIG_ADDR);
  assign cpu_din = mc_dout;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic r_parity;

  // Free-running cycle parity, used to decide whether START needs an ALIGN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end
`endif

  // Sequencer: page latch, byte counter and state advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_page  <= 8'h00;
      r_cnt   <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_trig) begin
            r_page  <= cpu_dout;
            r_state <= START;
          end
        end
        START: begin
          r_cnt <= 8'h00;
`ifdef OAM_DMA_ODD_ALIGN_EN
          r_state <= r_parity ? ALIGN : READ;
`else
          r_state <= READ;
`endif
        end
        ALIGN: r_state <= READ;
        READ:  r_state <= WRITE;
        WRITE: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 8'd1;
            r_state <= READ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus mux: decoded straight from state so reset frees the bus in the same cycle.
  always_comb begin
    mc_addr    = cpu_addr;
    mc_wr      = cpu_wr;
    mc_din     = cpu_dout;
    cpu_rdy    = 1'b1;
    dma_active = 1'b0;
    case (r_state)
      START, ALIGN: begin
        mc_wr      = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      READ: begin
        mc_addr    = {r_page, r_cnt};
        mc_wr      = 1'b0;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      WRITE: begin
        mc_addr    = DST_ADDR;
        mc_wr      = 1'b1;
        mc_din     = mc_dout;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
